if1_fetch_queue: RTL

IF1_FETCH_QUEUE -- requirements
Module: if1_fetch_queue

---
 rtl/if1_fetch_queue_pkg.sv | 15 +
 rtl/if1_slot_align.sv | 28 ++
 rtl/if1_fetch_queue.sv | 106 ++++++++++
 3 files changed

// File: rtl/if1_fetch_queue_pkg.sv
// if1_fetch_queue_pkg: shared constants and packet layout for the IF1 fetch queue
// Contents: INST_NOP filler word, exception/flag widths, per-packet metadata struct.
package if1_fetch_queue_pkg;
    localparam logic [31:0] INST_NOP = 32'h03400000;
    localparam int EXCP_W = 7;
    localparam int FLAG_W = 2;
    typedef struct packed {
        logic [31:0]       pc;
        logic [31:0]       pc_next;
        logic [31:0]       badv;
        logic [31:0]       cookie;
        logic [EXCP_W-1:0] exception;
        logic [FLAG_W-1:0] excp_flag;
    } pkt_meta_t;
endpackage

// File: rtl/if1_slot_align.sv
// if1_slot_align: combinational slot alignment of one fetch packet
// Ports:
//   pc_slot   in  log2(FETCH_NUM)  slot offset taken from the packet PC
//   rdata     in  32*FETCH_NUM     raw instruction words, slot 0 in the LSBs
//   excp_flag in  FLAG_W           nonzero marks the packet as excepted
//   inst      out 32*FETCH_NUM     aligned words, NOP below the offset or on exception
//   mask      out FETCH_NUM        per-slot valid bits
module if1_slot_align
    import if1_fetch_queue_pkg::*;
#(
    parameter int FETCH_NUM = 2
) (
    input  logic [$clog2(FETCH_NUM)-1:0] pc_slot,
    input  logic [32*FETCH_NUM-1:0]      rdata,
    input  logic [FLAG_W-1:0]            excp_flag,
    output logic [32*FETCH_NUM-1:0]      inst,
    output logic [FETCH_NUM-1:0]         mask
);
    localparam int OW = $clog2(FETCH_NUM);
    logic excp;
    assign excp = |excp_flag;
    // An excepted packet carries no instructions but keeps one mask bit at the
    // offset so decode still sees exactly one slot to raise the exception on.
    for (genvar s = 0; s < FETCH_NUM; s++) begin : g_slot
        assign inst[32*s +: 32] = (excp || OW'(s) < pc_slot) ? INST_NOP : rdata[32*s +: 32];
        assign mask[s] = excp ? (OW'(s) == pc_slot) : (OW'(s) >= pc_slot);
    end
endmodule

// File: rtl/if1_fetch_queue.sv
// if1_fetch_queue: IF1 fetch packet queue with push-time slot alignment
// Ports: clk, rstn (sync, active-low), flush; in_valid/in_ready with in_pc, in_pc_next,
//   in_rdata, in_badv, in_cookie, in_exception, in_excp_flag; out_valid/out_ready with
//   out_pc, out_pc_next, out_badv, out_cookie, out_exception, out_excp_flag, out_inst,
//   out_inst_mask. With IF1_FETCH_QUEUE_PERF_EN defined: perf_full_stall, perf_empty_bubble.
module if1_fetch_queue
    import if1_fetch_queue_pkg::*;
#(
    parameter int FETCH_NUM = 2,
    parameter int DEPTH     = 2
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_pc,
    input  logic [31:0]            in_pc_next,
    input  logic [32*FETCH_NUM-1:0] in_rdata,
    input  logic [31:0]            in_badv,
    input  logic [31:0]            in_cookie,
    input  logic [EXCP_W-1:0]      in_exception,
    input  logic [FLAG_W-1:0]      in_excp_flag,
`ifdef IF1_FETCH_QUEUE_PERF_EN
    output logic [31:0]            perf_full_stall,
    output logic [31:0]            perf_empty_bubble,
`endif
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_pc,
    output logic [31:0]            out_pc_next,
    output logic [31:0]            out_badv,
    output logic [31:0]            out_cookie,
    output logic [EXCP_W-1:0]      out_exception,
    output logic [FLAG_W-1:0]      out_excp_flag,
    output logic [32*FETCH_NUM-1:0] out_inst,
    output logic [FETCH_NUM-1:0]   out_inst_mask
);
    localparam int AW = $clog2(DEPTH);
    localparam int OW = $clog2(FETCH_NUM);
    logic [AW-1:0] wptr, rptr;
    logic [AW:0] count;
    logic push, pop;
    logic [32*FETCH_NUM-1:0] inst_mem [DEPTH];
    logic [FETCH_NUM-1:0] mask_mem [DEPTH];
    pkt_meta_t meta_mem [DEPTH];
    logic [32*FETCH_NUM-1:0] align_inst;
    logic [FETCH_NUM-1:0] align_mask;
    pkt_meta_t head;

    if1_slot_align #(.FETCH_NUM(FETCH_NUM)) u_align (
        .pc_slot  (in_pc[1+OW:2]),
        .rdata    (in_rdata),
        .excp_flag(in_excp_flag),
        .inst     (align_inst),
        .mask     (align_mask)
    );

    assign in_ready  = count != (AW+1)'(DEPTH);
    assign out_valid = (count != '0) && !flush;
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!rstn || flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop) rptr <= rptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem[wptr] <= align_inst;
            mask_mem[wptr] <= align_mask;
            meta_mem[wptr] <= '{in_pc, in_pc_next, in_badv, in_cookie, in_exception, in_excp_flag};
        end
    end

    // Outputs are forced to zero whenever nothing valid is presented.
    assign head          = out_valid ? meta_mem[rptr] : '0;
    assign out_inst      = out_valid ? inst_mem[rptr] : '0;
    assign out_inst_mask = out_valid ? mask_mem[rptr] : '0;
    assign out_pc        = head.pc;
    assign out_pc_next   = head.pc_next;
    assign out_badv      = head.badv;
    assign out_cookie    = head.cookie;
    assign out_exception = head.exception;
    assign out_excp_flag = head.excp_flag;

`ifdef IF1_FETCH_QUEUE_PERF_EN
    always_ff @(posedge clk) begin
        if (!rstn) begin
            perf_full_stall   <= '0;
            perf_empty_bubble <= '0;
        end else begin
            if (in_valid && !in_ready) perf_full_stall <= perf_full_stall + 32'd1;
            if (!out_valid && out_ready) perf_empty_bubble <= perf_empty_bubble + 32'd1;
        end
    end
`endif
endmodule
